// File: rtl/ws2812_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ws2812_tx_pkg
//  Purpose  : Shared constants and types for the WS2812 serializer.
//             Holds the NRZ bit-timing rates, the bits-per-LED constant and
//             the frame FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ws2812_tx_pkg;

  // WS2812 bit timing, expressed as rates so that CLK/rate gives cycles.
  localparam int WS_BIT_RATE_HZ = 800_000;    // 1.25 us bit period
  localparam int WS_T0H_RATE_HZ = 2_500_000;  // 0.4 us high time for a '0'
  localparam int WS_T1H_RATE_HZ = 1_250_000;  // 0.8 us high time for a '1'
  localparam int HZ_PER_MHZ     = 1_000_000;

  // Each LED consumes 24 bits (three 8-bit colour channels).
  localparam int BITS_PER_LED   = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : ws2812_bit_timer
//  Purpose  : Per-bit cycle counter and high/low compare for the WS2812 line.
//             The line level is registered and reflects the counter value of
//             the cycle in which it is visible, so every bit starts high.
//  Ports    : clk, reset   - clock, synchronous active-high reset
//             start        - load the first bit of a frame (cycle 0, high)
//             en           - frame transmission in progress
//             bit_val      - value of the bit currently being sent
//             last         - current bit is the final bit of the frame
//             level_o      - registered line level
//             bit_done     - current cycle is the last cycle of this bit
//  Revision : 1.0 - initial release
// ============================================================================
module ws2812_bit_timer #(
  parameter int T_BIT = 31,
  parameter int T0H   = 10,
  parameter int T1H   = 20,
  parameter int CYC_W = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic en,
  input  logic bit_val,
  input  logic last,
  output logic level_o,
  output logic bit_done
);

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             level_q, level_d;
  logic [CYC_W-1:0] cyc_inc;
  logic [CYC_W-1:0] thr;

  assign cyc_inc  = cyc_q + CYC_W'(1);
  assign thr      = bit_val ? CYC_W'(T1H) : CYC_W'(T0H);
  assign bit_done = en && (cyc_q == CYC_W'(T_BIT - 1));

  // The level computed here becomes visible in the cycle whose count is
  // cyc_d, so the compare is made against the next count, not the current.
  always_comb begin
    cyc_d   = '0;
    level_d = 1'b0;
    if (start) begin
      cyc_d   = '0;
      level_d = 1'b1;
    end else if (en) begin
      if (bit_done) begin
        // A new bit always opens with a high phase; after the last bit the
        // line must drop straight into the latch gap.
        cyc_d   = '0;
        level_d = !last;
      end else begin
        cyc_d   = cyc_inc;
        level_d = (cyc_inc < thr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cyc_q   <= cyc_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/ws2812_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ws2812_tx
//  Purpose  : WS2812 single-wire serializer. Double-buffers an LED frame,
//             sends it LSB-first with 800 kHz NRZ pulse-width coding and
//             closes every frame with a low latch gap. Updates arriving
//             while busy collapse into one pending frame.
//  Ports    : clk    - system clock
//             reset  - synchronous active-high reset
//             data   - frame to send (bit 0 first)
//             update - single-cycle transmit request
//             led_o  - registered serial line to the LED chain
//             busy   - high during a frame and its latch gap
//  Revision : 1.0 - initial release
// ============================================================================
module ws2812_tx
  import ws2812_tx_pkg::*;
#(
  parameter int CLK_SPEED = 25_000_000,
  parameter int LED_CNT   = 3,
  parameter int RESET_US  = 80
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [LED_CNT*BITS_PER_LED-1:0] data,
  input  logic                            update,
  output logic                            led_o,
  output logic                            busy
);

  localparam int DATAWIDTH = LED_CNT * BITS_PER_LED;
  localparam int T_BIT     = CLK_SPEED / WS_BIT_RATE_HZ;
  localparam int T0H       = CLK_SPEED / WS_T0H_RATE_HZ;
  localparam int T1H       = CLK_SPEED / WS_T1H_RATE_HZ;
  localparam int T_RES     = (CLK_SPEED / HZ_PER_MHZ) * RESET_US;
  localparam int CYC_W     = $clog2(max_int(T_RES, T_BIT) + 1);
  localparam int IDX_W     = $clog2(DATAWIDTH + 1);

  state_e                 state_q, state_d;
  logic [DATAWIDTH-1:0]   shadow_q, shadow_d;
  logic                   pending_q, pending_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [CYC_W-1:0]       cyc_q, cyc_d;     // latch-gap counter
  logic                   busy_q, busy_d;

  logic                   start;
  logic                   send_en;
  logic                   bit_done;
  logic                   last_bit;
  logic                   cur_bit;

  assign send_en  = (state_q == ST_SEND);
  assign last_bit = (bit_idx_q == IDX_W'(DATAWIDTH - 1));
  assign cur_bit  = shadow_q[bit_idx_q];

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    bit_idx_d = bit_idx_q;
    cyc_d     = cyc_q;
    busy_d    = busy_q;
    start     = 1'b0;
    // Any request while not idle is remembered once; the data itself is
    // captured only when that pending frame actually starts.
    pending_d = pending_q | (update && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (update || pending_q) begin
          shadow_d  = data;
          pending_d = 1'b0;
          bit_idx_d = '0;
          cyc_d     = '0;
          busy_d    = 1'b1;
          start     = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bit_done) begin
          if (last_bit) begin
            cyc_d   = '0;
            state_d = ST_LATCH;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      ST_LATCH: begin
        if (cyc_q == CYC_W'(T_RES - 1)) begin
          cyc_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      bit_idx_q <= '0;
      cyc_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      bit_idx_q <= bit_idx_d;
      cyc_q     <= cyc_d;
      busy_q    <= busy_d;
    end
  end

  ws2812_bit_timer #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H),
    .CYC_W (CYC_W)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .en       (send_en),
    .bit_val  (cur_bit),
    .last     (last_bit),
    .level_o  (led_o),
    .bit_done (bit_done)
  );

  assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ws2812_tx
//  Purpose  : Self-checking bench for ws2812_tx. Frames are compared cycle by
//             cycle against an arithmetic waveform model and decoded back
//             from measured pulse widths.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_tx;

  localparam int CLK_SPEED = 25_000_000;
  localparam int LED_CNT   = 3;
  localparam int RESET_US  = 80;
  localparam int DW        = LED_CNT * 24;
  localparam int T_BIT     = CLK_SPEED / 800_000;
  localparam int T0H       = CLK_SPEED / 2_500_000;
  localparam int T1H       = CLK_SPEED / 1_250_000;
  localparam int T_RES     = (CLK_SPEED / 1_000_000) * RESET_US;
  localparam int FRAME     = DW * T_BIT;

  logic          clk = 1'b0;
  logic          reset;
  logic          update;
  logic [DW-1:0] data;
  logic          led_o;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #20 clk = ~clk;

  ws2812_tx #(
    .CLK_SPEED (CLK_SPEED),
    .LED_CNT   (LED_CNT),
    .RESET_US  (RESET_US)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .data   (data),
    .update (update),
    .led_o  (led_o),
    .busy   (busy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level k cycles after the frame's first high cycle.
  function automatic logic model_level(input logic [DW-1:0] f, input int k);
    int b;
    int c;
    if (k >= FRAME) return 1'b0;
    b = k / T_BIT;
    c = k % T_BIT;
    return (c < (f[b] ? T1H : T0H));
  endfunction

  function automatic logic [DW-1:0] rand_frame();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Drive one update pulse; returns at frame cycle 0.
  task automatic pulse(input logic [DW-1:0] d);
    data   = d;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  // Entered at frame cycle 0; leaves at the first idle cycle after the gap.
  task automatic check_frame(input string tag, input logic [DW-1:0] f,
                             input int upd_a, input int upd_b, input int upd_c,
                             input int mid_cyc, input logic [DW-1:0] mid_data,
                             output logic [DW-1:0] dec);
    int bad_led;
    int bad_busy;
    int hi;
    bad_led  = 0;
    bad_busy = 0;
    hi       = 0;
    dec      = '0;
    for (int k = 0; k < FRAME + T_RES; k++) begin
      if (led_o !== model_level(f, k)) bad_led++;
      if (busy !== 1'b1) bad_busy++;
      if (k < FRAME) begin
        if (led_o === 1'b1) hi++;
        if ((k % T_BIT) == T_BIT - 1) begin
          dec[k / T_BIT] = (hi > (T0H + T1H) / 2);
          hi = 0;
        end
      end
      update = (k == upd_a) || (k == upd_b) || (k == upd_c);
      if (k == mid_cyc) data = mid_data;
      @(negedge clk);
    end
    update = 1'b0;
    chk({tag, "_wave_errs"}, DW'(bad_led), '0);
    chk({tag, "_busy_errs"}, DW'(bad_busy), '0);
    chk({tag, "_decoded"}, dec, f);
    chk({tag, "_end_busy"}, DW'(busy), '0);
    chk({tag, "_end_led"}, DW'(led_o), '0);
  endtask

  task automatic expect_restart(input string tag);
    @(negedge clk);
    chk({tag, "_restart_led"}, DW'(led_o), DW'(1));
    chk({tag, "_restart_busy"}, DW'(busy), DW'(1));
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int act;
    act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (led_o !== 1'b0 || busy !== 1'b0) act++;
    end
    chk({tag, "_quiet"}, DW'(act), '0);
  endtask

  initial begin
    logic [DW-1:0] f;
    logic [DW-1:0] g;
    logic [DW-1:0] dec;
    logic [7:0]    byte_v;

    reset  = 1'b1;
    update = 1'b0;
    data   = '0;
    repeat (3) @(negedge clk);
    chk("reset_led", DW'(led_o), '0);
    chk("reset_busy", DW'(busy), '0);
    reset = 1'b0;
    expect_quiet("post_reset", 5);

    // Single set bit at position 0, then random frames.
    pulse(DW'(1));
    check_frame("bit0", DW'(1), -1, -1, -1, -1, '0, dec);
    expect_quiet("bit0", 5);

    f = rand_frame();
    pulse(f);
    check_frame("rand1", f, -1, -1, -1, -1, '0, dec);
    expect_quiet("rand1", 5);

    // Update on the final latch cycle starts the next frame immediately.
    f = rand_frame();
    g = rand_frame();
    pulse(f);
    check_frame("rand2", f, -1, -1, FRAME + T_RES - 1, 40, g, dec);
    expect_restart("rand2");
    check_frame("rand2b", g, -1, -1, -1, -1, '0, dec);
    expect_quiet("rand2b", 5);

    // Reset in idle, then in the middle of bit 5 with a pending request.
    reset = 1'b1;
    @(negedge clk);
    chk("rst_idle_led", DW'(led_o), '0);
    chk("rst_idle_busy", DW'(busy), '0);
    reset = 1'b0;
    pulse({DW{1'b1}});
    for (int i = 0; i < 5 * T_BIT + 3; i++) begin
      update = (i == 20);
      @(negedge clk);
    end
    update = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    chk("rst_mid_led", DW'(led_o), '0);
    chk("rst_mid_busy", DW'(busy), '0);
    reset = 1'b0;
    expect_quiet("rst_mid_no_pending", T_RES + 50);
    f = rand_frame();
    pulse(f);
    check_frame("after_rst", f, -1, -1, -1, -1, '0, dec);
    expect_quiet("after_rst", 5);

    // Two updates during an all-ones frame collapse into one zero frame.
    pulse({DW{1'b1}});
    check_frame("ones", {DW{1'b1}}, 100, 900, -1, 50, '0, dec);
    expect_restart("ones");
    check_frame("zeros", '0, -1, -1, -1, -1, '0, dec);
    expect_quiet("zeros_no_third", 300);

    // Data changes mid-frame without update: the shadow copy is sent.
    f = rand_frame();
    pulse(f);
    check_frame("mid_change", f, -1, -1, -1, 200, ~f, dec);
    expect_quiet("mid_change", 5);

    // Update held for three cycles; pending frame samples later data.
    f = rand_frame();
    g = rand_frame();
    data   = f;
    update = 1'b1;
    @(negedge clk);
    check_frame("held3", f, 0, 1, -1, 10, g, dec);
    expect_restart("held3");
    check_frame("held3b", g, -1, -1, -1, -1, '0, dec);
    expect_quiet("held3b", 50);

    // Byte ordering: 0xA5 in every byte, MSB of each byte at bit 8k.
    f = {9{8'hA5}};
    pulse(f);
    check_frame("a5", f, -1, -1, -1, -1, '0, dec);
    for (int k = 0; k < DW / 8; k++) begin
      byte_v = '0;
      for (int j = 0; j < 8; j++) byte_v = {byte_v[6:0], dec[8 * k + j]};
      chk($sformatf("a5_byte%0d", k), DW'(byte_v), DW'(8'hA5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ws2812_tx.md
Name: ws2812_tx

Overview:
Downstream serializer for the I2C-to-LED path. It takes the flat LED frame assembled from received I2C bytes and drives a single-wire WS2812-style LED chain with 800 kHz NRZ pulse-width coding. Each frame ends with a latch/reset gap. Updates are double-buffered, so the upstream register can change while a frame is in flight.

Parameters:
- CLK_SPEED, 25_000_000: system clock frequency in Hz.
- LED_CNT, 3: number of LEDs in the chain; frame width is DATAWIDTH = LED_CNT*24.
- RESET_US, 80: length of the low latch gap after each frame, in microseconds.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- data  input  LED_CNT*24  frame to send; bit 0 goes out first; bits [8k+7:8k] are byte k, MSB of the byte at bit 8k.
- update  input  1  single-cycle request to transmit the current data.
- led_o  output  1  serial line to the first LED data-in.
- busy  output  1  high while a frame or its latch gap is in progress.

Behaviour:
- Derived constants (integer division, truncated):
  - T_BIT = CLK_SPEED/800_000
  - T0H = CLK_SPEED/2_500_000
  - T1H = CLK_SPEED/1_250_000
  - T_RES = (CLK_SPEED/1_000_000)*RESET_US
  - At 25 MHz: T_BIT=31, T0H=10, T1H=20, T_RES=2000.
- Reset: led_o=0, busy=0, pending=0, state=IDLE, all counters 0, shadow register 0.
- State IDLE:
  - led_o=0, busy=0.
  - When update=1 (or pending=1): copy data into shadow, clear pending, bit_idx=0, cyc=0, go to SEND.
  - busy rises on the cycle after update is sampled.
- State SEND:
  - Per bit: led_o=1 while cyc < (shadow[bit_idx] ? T1H : T0H), else 0.
  - cyc counts 0..T_BIT-1. At cyc=T_BIT-1: cyc<=0, bit_idx<=bit_idx+1.
  - After bit DATAWIDTH-1 completes: go to LATCH, cyc<=0.
  - The first rising edge of led_o appears 1 cycle after update is sampled. Frame duration is exactly DATAWIDTH*T_BIT cycles.
- State LATCH:
  - led_o=0 for exactly T_RES cycles, then go to IDLE.
  - If pending=1 on entry to IDLE, a new frame starts on the next cycle. The line minimum-low time is therefore T_RES+1 cycles.
- busy=1 in SEND and LATCH.
- update while busy:
  - Sets pending=1; the shadow is not changed mid-frame.
  - Multiple updates during one frame collapse into one pending flag.
  - data is sampled when the pending frame starts, not when update arrived.
- update on the same cycle the FSM returns to IDLE is treated as a normal IDLE start.
- reset mid-frame: led_o drops to 0 on the next edge and pending is cleared. No latch gap is generated; downstream LEDs see a truncated frame, which is acceptable.
- Widths:
  - cyc width = $clog2(max(T_RES,T_BIT)+1).
  - bit_idx width = $clog2(DATAWIDTH+1).
  - Comparisons are unsigned; no wrap-around is possible within a frame.
- led_o is registered (no combinational path from data or update).

Decomposition:
- Shared package/header (with the existing LED/I2C constants):
  - ws2812 timing constants: 800 kHz bit rate, 0.4 us T0H, 0.8 us T1H.
  - the 24-bits-per-LED constant.
  - state encodings IDLE/SEND/LATCH.
- One natural sub-module: ws2812_bit_timer.
  - Cycle counter plus high/low compare.
  - Inputs: start and bit value. Outputs: line level and bit_done.
- The frame FSM, shadow register and pending flag stay in ws2812_tx.

Test Plan:
1. LED_CNT=1, 25 MHz, data=24'h000001 (bit 0 = 1, rest 0), update pulse -> first bit high for 20 cycles, low for 11. Each remaining bit is high 10, low 21. Total 744 cycles, then 2000 cycles low. busy falls exactly 2744 cycles after its rise.
2. Reset asserted while in IDLE and again at bit 5 of a frame -> led_o=0 and busy=0 on the cycle after reset. The next update starts a clean frame from bit 0.
3. During frame 1 (data=24'hFFFFFF), pulse update twice with data=24'h0 -> exactly one further frame follows the latch gap. All its bits are 10-cycle highs; no third frame.
4. data changes mid-frame without update -> the transmitted waveform matches the shadow copy taken at frame start.
5. update held high for 3 consecutive cycles from IDLE -> one frame plus one pending frame. Second-frame start occurs exactly T_RES+1 cycles after the first frame's last bit ends.
6. LED_CNT=3, byte pattern 8'hA5 per byte loaded via bit ordering [8k]=MSB -> decoded pulse widths reproduce 8'hA5 nine times, MSB-first per byte.
